// File: rtl/router_pkg.sv
// Shared constants and header helpers for the 1x3 router.
// Header byte layout: destination address in [1:0], payload length in [7:2].
package router_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int FIFO_DEPTH   = 16;
    localparam int PKT_CNT_W    = 7;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    // Bytes still to drain after a header: payload length plus the parity byte.
    function automatic logic [PKT_CNT_W-1:0] hdr_pkt_count(input logic [DATA_WIDTH-1:0] hdr);
        return PKT_CNT_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [DATA_WIDTH-1:0] hdr);
        return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Write/read/status bundle between router_sync, a router_fifo and its destination.
interface router_fifo_if #(
    parameter int WIDTH = router_pkg::DATA_WIDTH
);
    logic             soft_reset;
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             in_packet;

    modport master (
        output soft_reset, write_enb, lfd_state, data_in, read_enb,
        input  data_out, full, empty, in_packet
    );

    modport slave (
        input  soft_reset, write_enb, lfd_state, data_in, read_enb,
        output data_out, full, empty, in_packet
    );
endinterface

// File: rtl/router_fifo.sv
// Per-destination packet FIFO: stores header-tagged bytes and tracks how many
// bytes of the packet currently being drained remain unread.
module router_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic         clock,
    input  logic         reset,
    router_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH:0]         mem [DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [PKT_CNT_W-1:0]   count;
    logic [WIDTH-1:0]       data_out_q;
    logic [WIDTH:0]         rd_entry;
    logic                   full;
    logic                   empty;
    logic                   wr_acc;
    logic                   rd_acc;

    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        wr_acc   = bus.write_enb && !full;
        rd_acc   = bus.read_enb && !empty;
        rd_entry = mem[rd_ptr[AW-1:0]];
    end

    // Storage has no reset; soft_reset only blocks the write of its own cycle.
    always_ff @(posedge clock) begin
        if (wr_acc && !bus.soft_reset)
            mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out_q <= '0;
        end else if (bus.soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out_q <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_acc) begin
                rd_ptr     <= rd_ptr + (AW+1)'(1);
                data_out_q <= rd_entry[WIDTH-1:0];
                if (rd_entry[WIDTH])
                    count <= hdr_pkt_count(rd_entry[DATA_WIDTH-1:0]);
                else if (count != '0)
                    count <= count - PKT_CNT_W'(1);
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.in_packet = (count != '0);

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo; read data checked by a scoreboard monitor.
module tb_router_fifo;
    logic clock = 1'b0;
    logic reset = 1'b1;

    router_fifo_if #(.WIDTH(8)) bus ();

    router_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a read handshake seen before an edge means data_out must
    // show the next queued byte after that edge.
    initial begin
        logic fire;
        logic [7:0] e;
        forever begin
            @(negedge clock);
            fire = bus.read_enb && !bus.empty && !reset && !bus.soft_reset;
            if (fire) begin
                @(posedge clock);
                #2;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got 0x%0h expected no read at %0t", bus.data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.data_out !== e) begin
                        errors++;
                        $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", bus.data_out, e, $time);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic we, input logic lfd, input logic [7:0] din,
                       input logic re, input logic sr);
        bus.write_enb  = we;
        bus.lfd_state  = lfd;
        bus.data_in    = din;
        bus.read_enb   = re;
        bus.soft_reset = sr;
        @(posedge clock);
        #1;
        bus.write_enb  = 1'b0;
        bus.lfd_state  = 1'b0;
        bus.read_enb   = 1'b0;
        bus.soft_reset = 1'b0;
    endtask

    task automatic wr(input logic lfd, input logic [7:0] din);
        cyc(1'b1, lfd, din, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] exp);
        exp_q.push_back(exp);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data_out"},  32'(bus.data_out),  32'h00);
        chk({tag, "_full"},      32'(bus.full),      32'h0);
        chk({tag, "_empty"},     32'(bus.empty),     32'h1);
        chk({tag, "_in_packet"}, 32'(bus.in_packet), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pkt1 [5];
        logic [4:0] inp1;
        pkt1[0] = 8'h0D; pkt1[1] = 8'hA1; pkt1[2] = 8'hA2; pkt1[3] = 8'hA3; pkt1[4] = 8'h5F;
        inp1 = 5'b01111;
        bus.write_enb = 1'b0; bus.lfd_state = 1'b0; bus.data_in = '0;
        bus.read_enb = 1'b0; bus.soft_reset = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(posedge clock); #1;

        // One packet: header 0x0D (len 3), 3 payload bytes, parity.
        for (int unsigned i = 0; i < 5; i++) begin
            wr(i == 0, pkt1[i]);
            if (i == 0) chk("empty_after_write", 32'(bus.empty), 32'h0);
        end
        for (int unsigned i = 0; i < 5; i++) begin
            rd(pkt1[i]);
            chk($sformatf("pkt1_in_packet_%0d", i), 32'(bus.in_packet), 32'(inp1[i]));
        end
        chk("pkt1_empty", 32'(bus.empty), 32'h1);

        // Fill to full, overflow write is dropped, then drain.
        for (int unsigned i = 0; i < 16; i++) begin
            wr(1'b0, 8'(8'h10 + i));
            if (i == 14) chk("full_at_15", 32'(bus.full), 32'h0);
        end
        chk("full_at_16", 32'(bus.full), 32'h1);
        wr(1'b0, 8'hFF);
        chk("full_after_drop", 32'(bus.full), 32'h1);
        for (int unsigned i = 0; i < 16; i++) begin
            rd(8'(8'h10 + i));
            if (i == 0) chk("full_clear_first_read", 32'(bus.full), 32'h0);
        end
        chk("fill_empty", 32'(bus.empty), 32'h1);
        chk("fill_in_packet", 32'(bus.in_packet), 32'h0);

        // Concurrent read and write with 8 stored; pointers wrap.
        for (int unsigned i = 0; i < 8; i++) wr(1'b0, 8'(8'h20 + i));
        for (int unsigned i = 0; i < 10; i++) begin
            exp_q.push_back(i < 8 ? 8'(8'h20 + i) : 8'(8'h30 + i - 8));
            cyc(1'b1, 1'b0, 8'(8'h30 + i), 1'b1, 1'b0);
            chk($sformatf("rw_full_%0d", i),  32'(bus.full),  32'h0);
            chk($sformatf("rw_empty_%0d", i), 32'(bus.empty), 32'h0);
        end
        for (int unsigned i = 2; i < 10; i++) rd(8'(8'h30 + i));
        chk("rw_drain_empty", 32'(bus.empty), 32'h1);

        // Write and read together on empty: read ignored, no bypass.
        cyc(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        chk("wr_rd_empty_hold", 32'(bus.data_out), 32'h39);
        chk("wr_rd_empty_flag", 32'(bus.empty), 32'h0);
        rd(8'h77);
        chk("wr_rd_empty_after", 32'(bus.empty), 32'h1);

        // soft_reset mid-packet beats a concurrent write.
        wr(1'b1, 8'h3C);
        for (int unsigned i = 0; i < 6; i++) wr(1'b0, 8'(8'h41 + i));
        rd(8'h3C); rd(8'h41); rd(8'h42);
        chk("sr_pre_in_packet", 32'(bus.in_packet), 32'h1);
        cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        chk_reset_vals("soft_rst");
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("sr_write_dropped", 32'(bus.empty), 32'h1);

        // Asynchronous reset between edges, mid-packet.
        wr(1'b1, 8'h0D); wr(1'b0, 8'hA1); wr(1'b0, 8'hA2);
        rd(8'h0D); rd(8'hA1);
        chk("ar_pre_in_packet", 32'(bus.in_packet), 32'h1);
        chk("ar_pre_data_out",  32'(bus.data_out),  32'hA1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk_reset_vals("post_rst");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
